// File: rtl/mandel_line_scheduler.sv
// Ping-pong line store between the Mandelbrot engines and the colour stream path.
// One bank fills from the engine lanes while the other drains as a handshaked pixel stream.
module mandel_line_scheduler #(
    parameter int X_SIZE  = 640,
    parameter int Y_SIZE  = 480,
    parameter int DEPTH_W = 10,
    parameter int N_LANES = 2,
    localparam int X_W = $clog2(X_SIZE),
    localparam int Y_W = $clog2(Y_SIZE)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    output logic                       eng_start,
    output logic [Y_W-1:0]             eng_line,
    input  logic                       eng_done,
    input  logic [N_LANES-1:0]         wr_we,
    input  logic [N_LANES*X_W-1:0]     wr_addr,
    input  logic [N_LANES*DEPTH_W-1:0] wr_data,
    output logic [DEPTH_W-1:0]         out_depth,
    output logic [X_W-1:0]             out_x,
    output logic [Y_W-1:0]             out_y,
    output logic                       out_sof,
    output logic                       out_eol,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       err
);

    typedef enum logic [1:0] {
        B_EMPTY    = 2'd0,
        B_FILLING  = 2'd1,
        B_FULL     = 2'd2,
        B_DRAINING = 2'd3
    } bank_state_e;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_BUSY = 1'b1
    } w_state_e;

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_STREAM = 1'b1
    } r_state_e;

    localparam logic [X_W:0]   X_END  = (X_W+1)'(X_SIZE);
    localparam logic [X_W-1:0] X_LAST = X_W'(X_SIZE-1);
    localparam logic [X_W-1:0] X_ONE  = X_W'(1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_SIZE-1);
    localparam logic [Y_W-1:0] Y_ONE  = Y_W'(1);

    // Line storage, deliberately left unreset
    logic [DEPTH_W-1:0] bank_mem [2][X_SIZE];

    bank_state_e        bank_state_q [2];
    bank_state_e        bank_state_d [2];
    logic [Y_W-1:0]     bank_tag_q   [2];
    logic [Y_W-1:0]     bank_tag_d   [2];

    w_state_e           w_state_q, w_state_d;
    logic               wr_bank_q, wr_bank_d;
    logic [Y_W-1:0]     wr_line_q, wr_line_d;
    logic               eng_start_q, eng_start_d;
    logic [Y_W-1:0]     eng_line_q, eng_line_d;
    logic               err_q, err_d;

    r_state_e           r_state_q, r_state_d;
    logic               rd_bank_q, rd_bank_d;
    logic [X_W-1:0]     rd_x_q, rd_x_d;
    logic [DEPTH_W-1:0] out_depth_q, out_depth_d;
    logic [X_W-1:0]     out_x_q, out_x_d;
    logic [Y_W-1:0]     out_y_q, out_y_d;
    logic               out_sof_q, out_sof_d;
    logic               out_eol_q, out_eol_d;
    logic               out_valid_q, out_valid_d;

    logic [X_W-1:0]     lane_addr_s [N_LANES];
    logic [DEPTH_W-1:0] lane_data_s [N_LANES];
    logic [N_LANES-1:0] lane_wr_s;
    logic               lane_err_s;
    logic [DEPTH_W-1:0] rd_data_s;

    // Lane decode: a write lands only while a line is being filled and the address is in range
    always_comb begin
        lane_wr_s  = {N_LANES{1'b0}};
        lane_err_s = 1'b0;
        for (int i = 0; i < N_LANES; i++) begin
            lane_addr_s[i] = wr_addr[i*X_W +: X_W];
            lane_data_s[i] = wr_data[i*DEPTH_W +: DEPTH_W];
            lane_wr_s[i]   = wr_we[i] && (w_state_q == W_BUSY) && ({1'b0, lane_addr_s[i]} < X_END);
            lane_err_s     = lane_err_s | (wr_we[i] && !lane_wr_s[i]);
        end
    end

    // Bank write port; later lanes are assigned last so the highest lane wins a collision
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_LANES; i++) begin
            if (lane_wr_s[i]) begin
                bank_mem[wr_bank_q][lane_addr_s[i]] <= lane_data_s[i];
            end
        end
    end

    // Asynchronous bank read feeding the output register
    always_comb begin
        rd_data_s = bank_mem[rd_bank_q][rd_x_q];
    end

    // Next-state logic for writer, reader and bank bookkeeping
    always_comb begin
        bank_state_d = bank_state_q;
        bank_tag_d   = bank_tag_q;
        w_state_d    = w_state_q;
        wr_bank_d    = wr_bank_q;
        wr_line_d    = wr_line_q;
        eng_start_d  = 1'b0;
        eng_line_d   = eng_line_q;
        err_d        = err_q | lane_err_s;
        r_state_d    = r_state_q;
        rd_bank_d    = rd_bank_q;
        rd_x_d       = rd_x_q;
        out_depth_d  = out_depth_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_sof_d    = out_sof_q;
        out_eol_d    = out_eol_q;
        out_valid_d  = out_valid_q;

        // Writer and reader only ever touch banks in disjoint states, so they never collide
        case (w_state_q)
            W_IDLE: begin
                if (run && (bank_state_q[wr_bank_q] == B_EMPTY)) begin
                    eng_start_d             = 1'b1;
                    eng_line_d              = wr_line_q;
                    bank_state_d[wr_bank_q] = B_FILLING;
                    bank_tag_d[wr_bank_q]   = wr_line_q;
                    w_state_d               = W_BUSY;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_BUSY: begin
                if (eng_done) begin
                    bank_state_d[wr_bank_q] = B_FULL;
                    wr_bank_d               = ~wr_bank_q;
                    wr_line_d               = (wr_line_q == Y_LAST) ? {Y_W{1'b0}} : (wr_line_q + Y_ONE);
                    w_state_d               = W_IDLE;
                end else begin
                    w_state_d = W_BUSY;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase

        case (r_state_q)
            R_IDLE: begin
                out_valid_d = out_valid_q && !out_ready;
                if (bank_state_q[rd_bank_q] == B_FULL) begin
                    bank_state_d[rd_bank_q] = B_DRAINING;
                    rd_x_d                  = {X_W{1'b0}};
                    r_state_d               = R_STREAM;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_STREAM: begin
                if (!out_valid_q || out_ready) begin
                    out_depth_d = rd_data_s;
                    out_x_d     = rd_x_q;
                    out_y_d     = bank_tag_q[rd_bank_q];
                    out_sof_d   = (rd_x_q == {X_W{1'b0}}) && (bank_tag_q[rd_bank_q] == {Y_W{1'b0}});
                    out_eol_d   = (rd_x_q == X_LAST);
                    out_valid_d = 1'b1;
                    if (rd_x_q == X_LAST) begin
                        bank_state_d[rd_bank_q] = B_EMPTY;
                        rd_bank_d               = ~rd_bank_q;
                        rd_x_d                  = {X_W{1'b0}};
                        r_state_d               = R_IDLE;
                    end else begin
                        rd_x_d    = rd_x_q + X_ONE;
                        r_state_d = R_STREAM;
                    end
                end else begin
                    r_state_d = R_STREAM;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                bank_state_q[b] <= B_EMPTY;
                bank_tag_q[b]   <= {Y_W{1'b0}};
            end
            w_state_q   <= W_IDLE;
            wr_bank_q   <= 1'b0;
            wr_line_q   <= {Y_W{1'b0}};
            eng_start_q <= 1'b0;
            eng_line_q  <= {Y_W{1'b0}};
            err_q       <= 1'b0;
            r_state_q   <= R_IDLE;
            rd_bank_q   <= 1'b0;
            rd_x_q      <= {X_W{1'b0}};
            out_depth_q <= {DEPTH_W{1'b0}};
            out_x_q     <= {X_W{1'b0}};
            out_y_q     <= {Y_W{1'b0}};
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            bank_state_q <= bank_state_d;
            bank_tag_q   <= bank_tag_d;
            w_state_q    <= w_state_d;
            wr_bank_q    <= wr_bank_d;
            wr_line_q    <= wr_line_d;
            eng_start_q  <= eng_start_d;
            eng_line_q   <= eng_line_d;
            err_q        <= err_d;
            r_state_q    <= r_state_d;
            rd_bank_q    <= rd_bank_d;
            rd_x_q       <= rd_x_d;
            out_depth_q  <= out_depth_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign eng_start = eng_start_q;
    assign eng_line  = eng_line_q;
    assign err       = err_q;
    assign out_depth = out_depth_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mandel_line_scheduler.sv
// Randomised bench for mandel_line_scheduler: engine model, consumer model and pixel scoreboard.
// X_SIZE is 10 (not a power of two) so an out-of-range write address is representable.
module tb_mandel_line_scheduler;

    localparam int X_SIZE  = 10;
    localparam int Y_SIZE  = 4;
    localparam int DEPTH_W = 10;
    localparam int N_LANES = 2;
    localparam int X_W     = $clog2(X_SIZE);
    localparam int Y_W     = $clog2(Y_SIZE);

    logic                       clk;
    logic                       reset;
    logic                       run;
    logic                       eng_start;
    logic [Y_W-1:0]             eng_line;
    logic                       eng_done;
    logic [N_LANES-1:0]         wr_we;
    logic [N_LANES*X_W-1:0]     wr_addr;
    logic [N_LANES*DEPTH_W-1:0] wr_data;
    logic [DEPTH_W-1:0]         out_depth;
    logic [X_W-1:0]             out_x;
    logic [Y_W-1:0]             out_y;
    logic                       out_sof;
    logic                       out_eol;
    logic                       out_valid;
    logic                       out_ready;
    logic                       err;

    mandel_line_scheduler #(
        .X_SIZE (X_SIZE),
        .Y_SIZE (Y_SIZE),
        .DEPTH_W(DEPTH_W),
        .N_LANES(N_LANES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .eng_start(eng_start),
        .eng_line (eng_line),
        .eng_done (eng_done),
        .wr_we    (wr_we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .out_depth(out_depth),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_sof  (out_sof),
        .out_eol  (out_eol),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DEPTH_W-1:0] d;
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic               sof;
        logic               eol;
    } pix_t;

    pix_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    int   cyc = 0;
    int   ready_mode;
    logic prev_valid;
    logic prev_ready;
    pix_t prev_pix;
    int   started, freed, accepted_lines, sof_seen, model_line, last_start_cyc;
    bit   saw_overlap;
    bit   eng_busy;
    int   eng_y;
    int   pend[$];
    int   line_val[X_SIZE];
    bit   collide_armed, collide_this;
    int   collide_step;
    bit   lat_pending_first, lat_armed;
    int   lat_done_cyc;
    bit   bp_armed;
    int   bp_left;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check_eq({pfx, "_eng_start"}, eng_start, 0);
        check_eq({pfx, "_eng_line"},  eng_line, 0);
        check_eq({pfx, "_out_valid"}, out_valid, 0);
        check_eq({pfx, "_out_depth"}, out_depth, 0);
        check_eq({pfx, "_out_x"},     out_x, 0);
        check_eq({pfx, "_out_y"},     out_y, 0);
        check_eq({pfx, "_out_sof"},   out_sof, 0);
        check_eq({pfx, "_out_eol"},   out_eol, 0);
        check_eq({pfx, "_err"},       err, 0);
    endtask

    task automatic model_reset();
        sb.delete();
        pend.delete();
        eng_busy       = 1'b0;
        model_line     = 0;
        started        = 0;
        freed          = 0;
        accepted_lines = 0;
        prev_valid     = 1'b0;
        prev_ready     = 1'b1;
        bp_left        = 0;
        collide_this   = 1'b0;
        lat_armed      = 1'b0;
        wr_we          = '0;
        wr_addr        = '0;
        wr_data        = '0;
        eng_done       = 1'b0;
    endtask

    task automatic lane_write(input int lane, input int addr, input int val);
        wr_we[lane]                       = 1'b1;
        wr_addr[lane*X_W +: X_W]          = X_W'(addr);
        wr_data[lane*DEPTH_W +: DEPTH_W]  = DEPTH_W'(val);
    endtask

    // One clock of the environment: observe at the falling edge, then drive the next inputs
    task automatic cycle();
        pix_t cur;
        pix_t exp_p;
        bit   newp;
        int   order[X_SIZE];
        int   j, t;
        @(negedge clk);
        cyc++;
        cur.d = out_depth; cur.x = out_x; cur.y = out_y; cur.sof = out_sof; cur.eol = out_eol;

        if (prev_valid && !prev_ready) begin
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_pixel", 32'(cur), 32'(prev_pix));
        end
        if (lat_armed && cyc == lat_done_cyc + 2) check_eq("latency_pre", out_valid, 0);
        if (lat_armed && cyc == lat_done_cyc + 3) begin
            check_eq("latency_valid", out_valid, 1);
            check_eq("latency_x", out_x, 0);
            lat_armed = 1'b0;
        end

        if (bp_armed && out_valid && out_x == X_W'(3)) begin
            bp_armed = 1'b0;
            bp_left  = 20;
        end
        if (bp_left > 0) begin
            out_ready = 1'b0;
            if (bp_left == 1) check_eq("bp_frozen_x", out_x, 3);
            bp_left--;
        end else begin
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end

        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_pixel", 1, 0);
            end else begin
                exp_p = sb.pop_front();
                check_eq("pix_depth", out_depth, exp_p.d);
                check_eq("pix_x",     out_x,     exp_p.x);
                check_eq("pix_y",     out_y,     exp_p.y);
                check_eq("pix_sof",   out_sof,   exp_p.sof);
                check_eq("pix_eol",   out_eol,   exp_p.eol);
            end
            if (out_eol) accepted_lines++;
            if (out_sof) sof_seen++;
        end
        newp = out_valid && !(prev_valid && !prev_ready);
        if (newp && out_eol) freed++;

        if (eng_start) begin
            check_eq("eng_line", eng_line, model_line % Y_SIZE);
            check_eq("start_while_busy", eng_busy, 0);
            started++;
            last_start_cyc = cyc;
            check_eq("lines_outstanding_le2", (started - freed <= 2), 1);
            if (started >= 2 && out_valid) saw_overlap = 1'b1;
            eng_busy     = 1'b1;
            eng_y        = model_line % Y_SIZE;
            model_line++;
            collide_this = collide_armed;
            collide_armed = 1'b0;
            collide_step = 0;
            for (int x = 0; x < X_SIZE; x++) begin
                line_val[x] = x + 10 * eng_y;
                order[x]    = x;
            end
            for (int i = X_SIZE - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = order[i]; order[i] = order[j]; order[j] = t;
            end
            pend.delete();
            for (int x = 0; x < X_SIZE; x++) pend.push_back(order[x]);
        end

        wr_we = '0; wr_addr = '0; wr_data = '0; eng_done = 1'b0;
        if (eng_busy) begin
            if (pend.size() > 0) begin
                for (int l = 0; l < N_LANES; l++) begin
                    if (pend.size() > 0 && $urandom_range(0, 3) != 0) begin
                        t = pend.pop_front();
                        lane_write(l, t, line_val[t]);
                    end
                end
            end else if (collide_this && collide_step == 0) begin
                lane_write(0, 5, 1);
                lane_write(1, 5, 2);
                line_val[5]  = 2;
                collide_step = 1;
            end else if (collide_this && collide_step == 1) begin
                lane_write(0, 12, 7);
                collide_step = 2;
            end else begin
                eng_done = 1'b1;
                eng_busy = 1'b0;
                for (int x = 0; x < X_SIZE; x++) begin
                    exp_p.d   = DEPTH_W'(line_val[x]);
                    exp_p.x   = X_W'(x);
                    exp_p.y   = Y_W'(eng_y);
                    exp_p.sof = (x == 0 && eng_y == 0);
                    exp_p.eol = (x == X_SIZE - 1);
                    sb.push_back(exp_p);
                end
                if (lat_pending_first) begin
                    lat_pending_first = 1'b0;
                    lat_armed         = 1'b1;
                    lat_done_cyc      = cyc;
                end
            end
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_pix   = cur;
    endtask

    initial begin
        int c0, target, stop_started;
        bit hit;
        reset = 1'b1; run = 1'b0; out_ready = 1'b1; ready_mode = 0;
        collide_armed = 1'b0; bp_armed = 1'b0; saw_overlap = 1'b0; sof_seen = 0;
        lat_pending_first = 1'b0; last_start_cyc = -1;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;

        // eng_done while idle is ignored and must not raise err
        @(negedge clk); eng_done = 1'b1;
        @(negedge clk); eng_done = 1'b0;
        @(negedge clk);
        check_eq("idle_done_err", err, 0);
        check_eq("idle_no_start", eng_start, 0);

        // Phase 1: fast consumer, first-request and first-pixel timing
        lat_pending_first = 1'b1;
        run = 1'b1;
        c0 = cyc;
        cycle();
        check_eq("first_start_cycle", last_start_cyc, c0 + 1);
        cycle();
        check_eq("start_one_cycle", eng_start, 0);
        for (int i = 0; i < 2000 && accepted_lines < Y_SIZE; i++) cycle();
        check_eq("p1_frame_done", accepted_lines >= Y_SIZE, 1);
        check_eq("p1_err_clear", err, 0);

        // Phase 2: slow consumer, collision + bad address line, backpressure hold, frame wrap
        ready_mode = 1; collide_armed = 1'b1; bp_armed = 1'b1; sof_seen = 0;
        target = accepted_lines + 2 * Y_SIZE;
        for (int i = 0; i < 6000 && accepted_lines < target; i++) cycle();
        check_eq("p2_lines_done", accepted_lines >= target, 1);
        check_eq("p2_overlap", saw_overlap, 1);
        check_eq("p2_err_sticky", err, 1);
        check_eq("p2_bp_seen", bp_armed, 0);
        check_eq("p2_wrap_sof", sof_seen >= 2, 1);

        // Phase 3: reset in the middle of line 2
        ready_mode = 2;
        hit = 1'b0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            cycle();
            hit = out_valid && out_y == Y_W'(2) && out_x == X_W'(5);
        end
        check_eq("p3_reset_point", hit, 1);
        reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs_zero("midreset_hold");
        ready_mode = 0;
        lat_pending_first = 1'b1;
        reset = 1'b0;
        c0 = cyc;
        cycle();
        check_eq("restart_start_cycle", last_start_cyc, c0 + 1);
        for (int i = 0; i < 2000 && accepted_lines < 3; i++) cycle();
        check_eq("p3_lines_done", accepted_lines >= 3, 1);

        // Stop issuing: in-flight and full lines still drain, nothing new starts
        run = 1'b0;
        ready_mode = 2;
        stop_started = started;
        repeat (400) cycle();
        check_eq("drain_no_new_start", started, stop_started);
        check_eq("drain_scoreboard_empty", sb.size(), 0);
        check_eq("drain_all_freed", freed, started);
        check_eq("drain_valid_low", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
